// File: rtl/priority_sensor_irq_servicer_if.sv
// Bundle between the sensor interrupt latches, the NI event port and the
// interrupt servicer. The master side is the servicer itself.
interface priority_sensor_irq_servicer_if #(
  parameter int N_SENSORS = 8,
  parameter int ID_W      = 3,
  parameter int TS_W      = 16
);
  logic [N_SENSORS-1:0] irq;
  logic [N_SENSORS-1:0] irq_mask;
  logic [N_SENSORS-1:0] clr;
  logic                 pkt_valid;
  logic                 pkt_ready;
  logic [ID_W-1:0]      pkt_id;
  logic [TS_W-1:0]      pkt_ts;
  logic                 busy;

  modport master (
    input  irq,
    input  irq_mask,
    input  pkt_ready,
    output clr,
    output pkt_valid,
    output pkt_id,
    output pkt_ts,
    output busy
  );

  modport slave (
    output irq,
    output irq_mask,
    output pkt_ready,
    input  clr,
    input  pkt_valid,
    input  pkt_id,
    input  pkt_ts,
    input  busy
  );
endinterface

// File: rtl/priority_sensor_irq_servicer.sv
// Fixed-priority servicer for latched sensor interrupts: picks the lowest
// eligible line, sends an (id, timestamp) record, then clears that latch.
module priority_sensor_irq_servicer #(
  parameter int N_SENSORS = 8,
  parameter int ID_W      = 3,
  parameter int TS_W      = 16
) (
  input logic clk,
  input logic grst,
  priority_sensor_irq_servicer_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    CLEAR = 2'd2,
    DROP  = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [TS_W-1:0]      ts_q;
  logic [ID_W-1:0]      selId_q, selId_d;
  logic [TS_W-1:0]      selTs_q, selTs_d;
  logic [ID_W-1:0]      pickId;
  logic [N_SENSORS-1:0] eligible;
  logic [N_SENSORS-1:0] selOneHot;
  logic                 anyEligible;
  logic                 selIrq;

  always_comb begin
    eligible    = bus.irq & ~bus.irq_mask;
    anyEligible = |eligible;
  end

  // Scanning downward lets the lowest set index overwrite any higher one.
  always_comb begin
    pickId = '0;
    for (int i = N_SENSORS - 1; i >= 0; i--) begin
      if (eligible[i]) pickId = ID_W'(i);
    end
  end

  always_comb begin
    selOneHot = '0;
    for (int i = 0; i < N_SENSORS; i++) begin
      selOneHot[i] = (selId_q == ID_W'(i));
    end
    selIrq = |(bus.irq & selOneHot);
  end

  always_comb begin
    state_d = state_q;
    selId_d = selId_q;
    selTs_d = selTs_q;
    case (state_q)
      IDLE: begin
        if (anyEligible) begin
          selId_d = pickId;
          selTs_d = ts_q;
          state_d = SEND;
        end
      end
      SEND: begin
        if (bus.pkt_ready) state_d = CLEAR;
      end
      CLEAR: begin
        state_d = DROP;
      end
      DROP: begin
        // The raw level is watched here, so a mask cannot end the wait early.
        if (!selIrq) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    bus.pkt_valid = (state_q == SEND);
    bus.pkt_id    = (state_q == SEND) ? selId_q : '0;
    bus.pkt_ts    = (state_q == SEND) ? selTs_q : '0;
    bus.clr       = (state_q == CLEAR) ? selOneHot : '0;
    bus.busy      = (state_q != IDLE);
  end

  always_ff @(posedge clk) begin
    if (grst) begin
      state_q <= IDLE;
      ts_q    <= '0;
      selId_q <= '0;
      selTs_q <= '0;
    end else begin
      state_q <= state_d;
      ts_q    <= ts_q + TS_W'(1);
      selId_q <= selId_d;
      selTs_q <= selTs_d;
    end
  end

endmodule
